// File: rtl/mano_ctrl_pkg.sv
// Shared constants for the basic-computer timing-and-control unit:
// opcode encodings, B-bit indices and per-opcode completion timesteps.
package mano_ctrl_pkg;

    localparam int DEFAULT_SC_WIDTH    = 4;
    localparam int DEFAULT_INSTR_WIDTH = 16;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_RIO = 3'd7;

    localparam int B_HLT = 0;
    localparam int B_INC = 5;
    localparam int B_SHL = 6;
    localparam int B_SHR = 7;
    localparam int B_CMA = 9;
    localparam int B_CLA = 11;

    localparam int STEP_RIO   = 3;
    localparam int STEP_SHORT = 4;
    localparam int STEP_LONG  = 5;
    localparam int STEP_ISZ   = 6;
    localparam int STEP_MAX   = 6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    // Last timestep of an instruction; SC clears at the end of this step.
    function automatic int completion_step(input logic [2:0] op);
        int step;
        step = STEP_LONG;
        case (op)
            OP_RIO:         step = STEP_RIO;
            OP_STA, OP_BUN: step = STEP_SHORT;
            OP_ISZ:         step = STEP_ISZ;
            default:        step = STEP_LONG;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter with clear/hold/increment control (clear wins) and
// a one-hot decode of the count onto the timing lines.
module mano_seq_counter
    import mano_ctrl_pkg::*;
#(
    parameter int SC_WIDTH = DEFAULT_SC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   hold,
    input  logic                   clr,
    output logic [SC_WIDTH-1:0]    sc,
    output logic [2**SC_WIDTH-1:0] t
);

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
        end else if (clr) begin
            sc <= '0;
        end else if (!hold && inc) begin
            sc <= sc + 1'b1;
        end
    end

    always_comb begin
        t     = '0;
        t[sc] = 1'b1;
    end

endmodule

// File: rtl/mano_control_sequencer.sv
// Timing-and-control unit: IR, sequence counter, D/T/I/r/p/B decodes and
// halt/resume. Defining MANO_SEQ_INT_EN adds the interrupt cycle (ien/fgi/fgo, int_r).
module mano_control_sequencer
    import mano_ctrl_pkg::*;
#(
    parameter int SC_WIDTH    = DEFAULT_SC_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   resume,
    output logic [2**SC_WIDTH-1:0] t,
    output logic [7:0]             d,
    output logic                   i,
    output logic                   r,
    output logic                   p,
    output logic [11:0]            b,
`ifdef MANO_SEQ_INT_EN
    input  logic                   ien,
    input  logic                   fgi,
    input  logic                   fgo,
    output logic                   int_r,
`endif
    output logic                   halted
);

    seq_state_t state_q, state_d;

    logic [INSTR_WIDTH-1:0] ir;
    logic [SC_WIDTH-1:0]    sc;
    logic [2**SC_WIDTH-1:0] t_raw;
    logic [2:0]             opcode;
    logic                   sc_inc, sc_hold, sc_clr;
    logic                   int_clr;
    logic                   ir_load;
    logic                   guard_fire;

`ifndef MANO_SEQ_INT_EN
    logic int_r;
    assign int_r = 1'b0;
`endif

    mano_seq_counter #(.SC_WIDTH(SC_WIDTH)) u_sc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sc_inc),
        .hold  (sc_hold),
        .clr   (sc_clr),
        .sc    (sc),
        .t     (t_raw)
    );

    assign halted      = (state_q == ST_HALT);
    assign t           = halted ? '0 : t_raw;
    assign opcode      = ir[14:12];
    assign i           = ir[15];
    assign b           = ir[11:0];
    assign r           = d[OP_RIO] & ~i & t[3];
    assign p           = d[OP_RIO] &  i & t[3];
    assign instr_ready = t[1] & ~halted & ~int_r;
    assign ir_load     = instr_valid & instr_ready;

    always_comb begin
        d         = '0;
        d[opcode] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: IR is reset explicitly because the D/I/B decodes are visible
    // outputs during T0/T1; an unreset IR would leak X into the gate blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= instr;
        end
    end

`ifdef MANO_SEQ_INT_EN
    // Interrupt request latches only outside T0..T2 so a cycle in flight is never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_r <= 1'b0;
        end else if (int_clr) begin
            int_r <= 1'b0;
        end else if (ien && (fgi || fgo) && !halted && sc > SC_WIDTH'(2)) begin
            int_r <= 1'b1;
        end
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path
    // through the case/if tree can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        sc_inc     = 1'b0;
        sc_hold    = 1'b0;
        sc_clr     = 1'b0;
        int_clr    = 1'b0;
        guard_fire = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (int_r && sc == SC_WIDTH'(2)) begin
                    sc_clr  = 1'b1;
                    int_clr = 1'b1;
                end else if (!int_r && sc == SC_WIDTH'(1) && !instr_valid) begin
                    sc_hold = 1'b1;
                end else if (r && b[B_HLT]) begin
                    sc_clr  = 1'b1;
                    state_d = ST_HALT;
                end else if (sc == SC_WIDTH'(completion_step(opcode))) begin
                    sc_clr = 1'b1;
                end else if (sc >= SC_WIDTH'(STEP_MAX)) begin
                    // Safety net only; legal decode always completes by T6.
                    sc_clr     = 1'b1;
                    guard_fire = 1'b1;
                end else begin
                    sc_inc = 1'b1;
                end
            end
            ST_HALT: begin
                sc_hold = 1'b1;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_mano_control_sequencer.sv
// Directed bench for mano_control_sequencer; build with +define+MANO_SEQ_INT_EN
// to include the interrupt-cycle vectors.
module tb_mano_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        resume;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i;
    logic        r;
    logic        p;
    logic [11:0] b;
    logic        halted;
`ifdef MANO_SEQ_INT_EN
    logic        ien;
    logic        fgi;
    logic        fgo;
    logic        int_r;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int guard_hits   = 0;

    always #5 clk = ~clk;

    mano_control_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .resume      (resume),
        .t           (t),
        .d           (d),
        .i           (i),
        .r           (r),
        .p           (p),
        .b           (b),
`ifdef MANO_SEQ_INT_EN
        .ien         (ien),
        .fgi         (fgi),
        .fgo         (fgo),
        .int_r       (int_r),
`endif
        .halted      (halted)
    );

    always @(posedge clk) begin
        if (dut.guard_fire) guard_hits++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // From T1: present an instruction for one accepting edge, land in T2.
    task automatic load(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        check("ready_at_load", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        resume      = 1'b0;
`ifdef MANO_SEQ_INT_EN
        ien = 1'b0;
        fgi = 1'b0;
        fgo = 1'b0;
`endif
        #2;
        check("rst_t", {16'd0, t}, 32'h0001);
        check("rst_d", {24'd0, d}, 32'h01);
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        #10 rst_n = 1'b1;
        check("post_rst_t", {16'd0, t}, 32'h0001);
        check("post_rst_halted", {31'd0, halted}, 32'd0);
        tick();
        check("t1_t", {16'd0, t}, 32'h0002);
        check("t1_ready", {31'd0, instr_ready}, 32'd1);

        // ADD: six cycles T0..T5
        load(16'h1123);
        check("add_d", {24'd0, d}, 32'h02);
        check("add_b", {20'd0, b}, 32'h123);
        ticks(3);
        check("add_t5", {16'd0, t}, 32'h0020);
        tick();
        check("add_end_t0", {16'd0, t}, 32'h0001);
        tick();

        // Stall at T1 for three cycles, then STA completes at T4
        for (int k = 0; k < 3; k++) begin
            check("stall_t", {16'd0, t}, 32'h0002);
            check("stall_ready", {31'd0, instr_ready}, 32'd1);
            tick();
        end
        load(16'h3010);
        check("sta_d", {24'd0, d}, 32'h08);
        ticks(2);
        check("sta_t4", {16'd0, t}, 32'h0010);
        tick();
        check("sta_end_t0", {16'd0, t}, 32'h0001);
        tick();

        // Register-reference INC
        load(16'h7020);
        check("inc_r_t2", {31'd0, r}, 32'd0);
        tick();
        check("inc_r_t3", {31'd0, r}, 32'd1);
        check("inc_p_t3", {31'd0, p}, 32'd0);
        check("inc_b", {20'd0, b}, 32'h020);
        tick();
        check("inc_end_t0", {16'd0, t}, 32'h0001);
        check("inc_r_t0", {31'd0, r}, 32'd0);
        tick();

        // HLT, five halted cycles, then RESUME
        load(16'h7001);
        tick();
        check("hlt_r_t3", {31'd0, r}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_t", {16'd0, t}, 32'h0000);
            check("halt_ready", {31'd0, instr_ready}, 32'd0);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_t0", {16'd0, t}, 32'h0001);
        tick();
        check("resume_t1", {16'd0, t}, 32'h0002);
        check("resume_ready", {31'd0, instr_ready}, 32'd1);

        // RESUME while running is ignored
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("idle_resume_halted", {31'd0, halted}, 32'd0);
        check("idle_resume_t", {16'd0, t}, 32'h0002);

        // Async reset at T4 of ISZ
        load(16'h6005);
        check("isz_d", {24'd0, d}, 32'h40);
        ticks(2);
        check("isz_t4", {16'd0, t}, 32'h0010);
        rst_n = 1'b0;
        #1;
        check("arst_t", {16'd0, t}, 32'h0001);
        check("arst_d", {24'd0, d}, 32'h01);
        check("arst_b", {20'd0, b}, 32'h000);
        check("arst_i", {31'd0, i}, 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Indirect LDA: I=1 adds no timestep
        load(16'hA123);
        check("lda_i", {31'd0, i}, 32'd1);
        check("lda_d", {24'd0, d}, 32'h04);
        ticks(3);
        check("lda_t5", {16'd0, t}, 32'h0020);
        tick();
        check("lda_end_t0", {16'd0, t}, 32'h0001);
        tick();

        // Full ISZ runs to T6
        load(16'h6005);
        ticks(4);
        check("isz_t6", {16'd0, t}, 32'h0040);
        tick();
        check("isz_end_t0", {16'd0, t}, 32'h0001);
        tick();

`ifdef MANO_SEQ_INT_EN
        load(16'h1123);
        tick();
        ien = 1'b1;
        fgi = 1'b1;
        tick();
        ien = 1'b0;
        fgi = 1'b0;
        check("int_set", {31'd0, int_r}, 32'd1);
        ticks(2);
        check("int_cyc_t0", {16'd0, t}, 32'h0001);
        check("int_ready_t0", {31'd0, instr_ready}, 32'd0);
        tick();
        check("int_cyc_t1", {16'd0, t}, 32'h0002);
        check("int_ready_t1", {31'd0, instr_ready}, 32'd0);
        tick();
        check("int_cyc_t2", {16'd0, t}, 32'h0004);
        check("int_ready_t2", {31'd0, instr_ready}, 32'd0);
        tick();
        check("int_clear", {31'd0, int_r}, 32'd0);
        check("int_end_t0", {16'd0, t}, 32'h0001);
        tick();
        check("int_after_ready", {31'd0, instr_ready}, 32'd1);
`endif

        check("guard_never", guard_hits, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
